// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS core: sequences fetch/decode/execute/memory/writeback.
// Optional macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes lock into TRAP and raise illegal_op.
module mips_multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ORI   = 6'b001101
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic [3:0] state_o
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    IEXEC  = 4'd11,
    IWB    = 4'd12,
    TRAP   = 4'd13
  } state_t;

  state_t     state_reg;
  logic [5:0] op_q_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      op_q_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE:   state_reg <= FETCH;
        FETCH:  if (mem_ready) state_reg <= DECODE;
        DECODE: begin
          op_q_reg <= opcode;
          if (opcode == OP_LW || opcode == OP_SW) state_reg <= MEMADR;
          else if (opcode == OP_RTYPE)            state_reg <= EXEC;
          else if (opcode == OP_BEQ)              state_reg <= BRANCH;
          else if (opcode == OP_J)                state_reg <= JUMP;
          else if (opcode == OP_ORI)              state_reg <= IEXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
          else                                    state_reg <= TRAP;
`else
          // Unknown opcodes retire silently as a NOP.
          else                                    state_reg <= FETCH;
`endif
        end
        // op_q_reg only ever holds lw or sw here.
        MEMADR: state_reg <= (op_q_reg == OP_SW) ? MEMWR : MEMRD;
        MEMRD:  if (mem_ready) state_reg <= MEMWB;
        MEMWB:  state_reg <= FETCH;
        MEMWR:  if (mem_ready) state_reg <= FETCH;
        EXEC:   state_reg <= ALUWB;
        ALUWB:  state_reg <= FETCH;
        BRANCH: state_reg <= FETCH;
        JUMP:   state_reg <= FETCH;
        IEXEC:  state_reg <= IWB;
        IWB:    state_reg <= FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
        TRAP:   state_reg <= TRAP;
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Moore decode of the state register; only FETCH/MEMWR gate a strobe with mem_ready.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    instr_done    = 1'b0;
    case (state_reg)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: alu_src_b = 2'b11;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
      end
      IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state_reg;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = (state_reg == TRAP);
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control; expected per-cycle state/outputs go through a scoreboard queue.
// Build with +define+CTRL_ILLEGAL_TRAP_EN to exercise the trap variant.
module tb_mips_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    logic [3:0] st;
    outs_t      o;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, alu_src_a;
  logic       reg_write, reg_dst, mem_to_reg, instr_done;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state_o;
  logic       illegal_obs;

  int checks   = 0;
  int failures = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .instr_done    (instr_done),
    .state_o       (state_o)
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_op    (illegal_obs)
`endif
  );

`ifndef CTRL_ILLEGAL_TRAP_EN
  assign illegal_obs = 1'b0;
`endif

  // Reference table: outputs required in each state.
  function automatic outs_t exp_outs(input logic [3:0] st, input logic mr);
    outs_t o;
    o = '0;
    case (st)
      4'd1:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
      4'd2:  o.alu_src_b = 2'b11;
      4'd3:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      4'd4:  begin o.mem_read = 1; o.iord = 1; end
      4'd5:  begin o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; end
      4'd6:  begin o.mem_write = 1; o.iord = 1; o.instr_done = mr; end
      4'd7:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      4'd8:  begin o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1; end
      4'd9:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; o.instr_done = 1; end
      4'd10: begin o.pc_write = 1; o.pc_source = 2'b10; o.instr_done = 1; end
      4'd11: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 2'b11; end
      4'd12: begin o.reg_write = 1; o.instr_done = 1; end
      4'd13: o.illegal = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t obs_outs();
    outs_t o;
    o = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
         alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, instr_done, illegal_obs};
    return o;
  endfunction

  task automatic push_exp(input logic [3:0] st, input logic mr);
    exp_t e;
    e.st = st;
    e.o  = exp_outs(st, mr);
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t  e;
    outs_t o;
    e = sb_q.pop_front();
    o = obs_outs();
    checks++;
    assert (state_o === e.st) else begin
      failures++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state_o, e.st);
    end
    checks++;
    assert (o === e.o) else begin
      failures++;
      $error("FAIL %s outputs observed=%h expected=%h", tag, o, e.o);
    end
    $display("t=%0t %s state=%0d outs=%h", $time, tag, state_o, o);
  endtask

  // One clock cycle: drive inputs just after the edge, check at the falling edge.
  task automatic cycle(input string tag, input logic [3:0] st, input logic mr, input logic [5:0] op);
    mem_ready = mr;
    opcode    = op;
    push_exp(st, mr);
    @(negedge clk);
    pop_check(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    opcode    = OP_RTYPE;
    repeat (2) @(posedge clk);
    #1;
    push_exp(4'd0, 1'b1);
    @(negedge clk);
    pop_check("reset_hold");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    cycle("rst_idle",   4'd0, 1, OP_LW);
    // lw with three wait cycles in MEMRD
    cycle("lw_fetch",   4'd1, 1, OP_LW);
    cycle("lw_decode",  4'd2, 1, OP_LW);
    cycle("lw_memadr",  4'd3, 1, OP_LW);
    cycle("lw_memrd_w", 4'd4, 0, OP_LW);
    cycle("lw_memrd_w", 4'd4, 0, OP_LW);
    cycle("lw_memrd_w", 4'd4, 0, OP_LW);
    cycle("lw_memrd",   4'd4, 1, OP_LW);
    cycle("lw_memwb",   4'd5, 1, OP_LW);
    // R-type, preceded by one FETCH wait
    cycle("r_fetch_w",  4'd1, 0, OP_RTYPE);
    cycle("r_fetch",    4'd1, 1, OP_RTYPE);
    cycle("r_decode",   4'd2, 1, OP_RTYPE);
    cycle("r_exec",     4'd7, 1, OP_RTYPE);
    cycle("r_aluwb",    4'd8, 1, OP_RTYPE);
    // beq then j
    cycle("beq_fetch",  4'd1, 1, OP_BEQ);
    cycle("beq_decode", 4'd2, 1, OP_BEQ);
    cycle("beq_branch", 4'd9, 1, OP_BEQ);
    cycle("j_fetch",    4'd1, 1, OP_J);
    cycle("j_decode",   4'd2, 1, OP_J);
    cycle("j_jump",     4'd10, 1, OP_J);
    // ori
    cycle("ori_fetch",  4'd1, 1, OP_ORI);
    cycle("ori_decode", 4'd2, 1, OP_ORI);
    cycle("ori_iexec",  4'd11, 1, OP_ORI);
    cycle("ori_iwb",    4'd12, 1, OP_ORI);
    // sw with one wait in MEMWR
    cycle("sw_fetch",   4'd1, 1, OP_SW);
    cycle("sw_decode",  4'd2, 1, OP_SW);
    cycle("sw_memadr",  4'd3, 1, OP_SW);
    cycle("sw_memwr_w", 4'd6, 0, OP_SW);
    cycle("sw_memwr",   4'd6, 1, OP_SW);
    // sw aborted by asynchronous reset while stalled in MEMWR
    cycle("swr_fetch",  4'd1, 1, OP_SW);
    cycle("swr_decode", 4'd2, 1, OP_SW);
    cycle("swr_memadr", 4'd3, 1, OP_SW);
    mem_ready = 1'b0;
    push_exp(4'd6, 1'b0);
    #2;
    pop_check("swr_memwr");
    reset_n = 1'b0;
    #1;
    push_exp(4'd0, 1'b0);
    pop_check("swr_abort");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle("abort_idle", 4'd0, 1, OP_BAD);
    // illegal opcode
    cycle("bad_fetch",  4'd1, 1, OP_BAD);
    cycle("bad_decode", 4'd2, 1, OP_BAD);
`ifdef CTRL_ILLEGAL_TRAP_EN
    cycle("bad_trap",   4'd13, 1, OP_RTYPE);
    cycle("bad_trap",   4'd13, 1, OP_RTYPE);
    cycle("bad_trap",   4'd13, 1, OP_RTYPE);
    reset_n = 1'b0;
    #1;
    push_exp(4'd0, 1'b1);
    pop_check("trap_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle("trap_idle",  4'd0, 1, OP_RTYPE);
    cycle("trap_fetch", 4'd1, 1, OP_RTYPE);
`else
    cycle("bad_nop",    4'd1, 1, OP_RTYPE);
    cycle("bad_next",   4'd2, 1, OP_RTYPE);
`endif

    checks++;
    assert (sb_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
